// File: rtl/ram_pkg.sv
// Shared definitions for the self-clearing single-port RAM slice:
// default geometry and the two-state clear/idle FSM encoding.
package ram_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 9;

   // Legacy-compatible state codes; the enum below is built from them.
   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_IDLE  = 1'b1;

   typedef enum logic [0:0] {
      CLEAR = ST_CLEAR,
      IDLE  = ST_IDLE
   } ram_state_t;

endpackage

// File: rtl/ram_core.sv
// Storage array for ram_sp_clr: one write port and one registered read port.
// The array itself carries no reset; only the read register is cleared.
module ram_core
   import ram_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] q
);

   logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

   // Write port: no reset, contents are initialised by the owner's clear sweep.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Read register: loads only on a read so q holds between reads.
   always_ff @(posedge clk) begin
      if (rst)     q <= '0;
      else if (re) q <= mem[raddr];
   end

endmodule

// File: rtl/ram_sp_clr.sv
// ram_sp_clr: single-port RAM that sweeps CLR_VAL into every location after
// reset, then serves pipelined reads and writes.
// Optional macro RAM_SP_CLR_OUTREG_EN adds an output register stage on
// rdata/rvalid (read latency 2 instead of 1); clear/ready timing is unchanged.
//
// Handshake: an access (en=1) is accepted on a rising edge only when
// ready=1; requests presented while ready=0 are dropped, not stalled.
// rvalid is a one-cycle pulse per accepted read, in issue order.
module ram_sp_clr
   import ram_pkg::*;
#(
   parameter int                DATA_W  = DEF_DATA_W,
   parameter int                ADDR_W  = DEF_ADDR_W,
   parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
   input  logic              rclk,
   input  logic              rst,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   output logic              ready,
   output ram_state_t        state_dbg
);

   localparam int DEPTH = 2**ADDR_W;
   // Counter is one bit wider than the address so completion never aliases.
   localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(DEPTH - 1);

   ram_state_t        state;
   logic [ADDR_W:0]   clr_cnt;
   logic              user_acc;
   logic              core_we;
   logic              core_re;
   logic [ADDR_W-1:0] core_waddr;
   logic [DATA_W-1:0] core_wdata;
   logic [DATA_W-1:0] core_q;
   logic              rvalid_q1;

   // FSM and clear counter: sweep every location once, then go idle.
   always_ff @(posedge rclk) begin
      if (rst) begin
         state   <= CLEAR;
         clr_cnt <= '0;
      end else if (state == CLEAR) begin
         clr_cnt <= clr_cnt + 1'b1;
         if (clr_cnt == CLR_LAST) state <= IDLE;
      end
   end

   assign ready     = (state == IDLE);
   assign state_dbg = state;
   assign user_acc  = ready & en;

   // Write-port mux: the clear sweep owns the port until the FSM is idle.
   always_comb begin
      core_we    = 1'b0;
      core_waddr = addr;
      core_wdata = wdata;
      if (!rst) begin
         if (state == CLEAR) begin
            core_we    = 1'b1;
            core_waddr = clr_cnt[ADDR_W-1:0];
            core_wdata = CLR_VAL;
         end else begin
            core_we    = user_acc & we;
         end
      end
   end

   assign core_re = ~rst & user_acc & ~we;

   ram_core #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_core (
      .clk   (rclk),
      .rst   (rst),
      .we    (core_we),
      .waddr (core_waddr),
      .wdata (core_wdata),
      .re    (core_re),
      .raddr (addr),
      .q     (core_q)
   );

   // First rvalid stage tracks the read register; reset drops in-flight reads.
   always_ff @(posedge rclk) begin
      if (rst) rvalid_q1 <= 1'b0;
      else     rvalid_q1 <= core_re;
   end

`ifdef RAM_SP_CLR_OUTREG_EN
   logic [DATA_W-1:0] rdata_q2;
   logic              rvalid_q2;

   // Extra output stage: delays data and valid together by one cycle.
   always_ff @(posedge rclk) begin
      if (rst) begin
         rdata_q2  <= '0;
         rvalid_q2 <= 1'b0;
      end else begin
         rdata_q2  <= core_q;
         rvalid_q2 <= rvalid_q1;
      end
   end

   assign rdata  = rdata_q2;
   assign rvalid = rvalid_q2;
`else
   assign rdata  = core_q;
   assign rvalid = rvalid_q1;
`endif

endmodule

// File: tb/tb_ram_sp_clr.sv
// Bench for ram_sp_clr: clear timing, reads/writes against an array model,
// reset behaviour. Read latency follows RAM_SP_CLR_OUTREG_EN.
module tb_ram_sp_clr;
   import ram_pkg::*;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 9;
   localparam int DEPTH  = 512;
   localparam logic [DATA_W-1:0] CLR_VAL = 8'h00;
`ifdef RAM_SP_CLR_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic              rclk;
   logic              rst;
   logic              en;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              rvalid;
   logic              ready;
   ram_state_t        state_dbg;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: memory contents, expected-output pipeline, last delivered data.
   logic [DATA_W-1:0] model_mem [DEPTH];
   logic [DATA_W:0]   exp_q[$];
   logic [DATA_W-1:0] last_rdata;

   ram_sp_clr #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .CLR_VAL (CLR_VAL)
   ) dut (
      .rclk      (rclk),
      .rst       (rst),
      .en        (en),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .rvalid    (rvalid),
      .ready     (ready),
      .state_dbg (state_dbg)
   );

   // Clock / reset block
   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   initial begin
      rst = 1'b1; en = 1'b0; we = 1'b0; addr = '0; wdata = '0;
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge rclk);
      #1;
   endtask

   task automatic set_in(input logic e, input logic w,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      en = e; we = w; addr = a; wdata = d;
   endtask

   task automatic random_in();
      set_in(1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))),
             ADDR_W'($urandom_range(0, DEPTH - 1)), DATA_W'($urandom_range(0, 255)));
   endtask

   // Memory is all CLR_VAL after a completed clear; outputs idle at 0.
   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = CLR_VAL;
      exp_q.delete();
      for (int i = 0; i < LAT - 1; i++) exp_q.push_back('0);
      last_rdata = '0;
   endtask

   // One IDLE-mode cycle: drive, update model, advance, return expected {rvalid, rdata}.
   task automatic issue(input logic e, input logic w,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        output logic [DATA_W:0] ent);
      logic [DATA_W:0] head;
      set_in(e, w, a, d);
      if (e && w) model_mem[a] = d;
      exp_q.push_back({e && !w, (e && !w) ? model_mem[a] : {DATA_W{1'b0}}});
      step();
      head = exp_q.pop_front();
      if (head[DATA_W]) last_rdata = head[DATA_W-1:0];
      ent = {head[DATA_W], last_rdata};
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      random_in();
      step();
      n_checks++;
      if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready); end
      n_checks++;
      if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
      n_checks++;
      if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h want 00", rdata); end
      rst = 1'b0;
      for (int i = 1; i <= DEPTH; i++) begin
         random_in();
         step();
         n_checks++;
         if (ready !== (i == DEPTH)) begin
            n_fail++; $display("FAIL clear_ready edge %0d: got %b want %b", i, ready, (i == DEPTH));
         end
         n_checks++;
         if (rvalid !== 1'b0) begin n_fail++; $display("FAIL clear_rvalid edge %0d: got %b want 0", i, rvalid); end
      end
      set_in(1'b0, 1'b0, '0, '0);
      model_clear();
   endtask

   task automatic test_clear_read();
      logic [DATA_W:0] ent;
      for (int c = 0; c <= LAT; c++) begin
         if (c == 0) issue(1'b1, 1'b0, 9'h1FF, '0, ent);
         else        issue(1'b0, 1'b0, '0, '0, ent);
         n_checks++;
         if ({rvalid, rdata} !== ent) begin
            n_fail++; $display("FAIL clear_read c%0d: got %b/%h want %b/%h", c, rvalid, rdata, ent[DATA_W], ent[DATA_W-1:0]);
         end
         if (c == LAT - 1) begin
            n_checks++;
            if (rvalid !== 1'b1 || rdata !== 8'h00) begin
               n_fail++; $display("FAIL clear_read_1ff: got %b/%h want 1/00", rvalid, rdata);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [DATA_W:0]   ent;
      logic [DATA_W-1:0] obs[$];
      logic [DATA_W-1:0] want [3];
      logic              op_en [5] = '{1, 1, 1, 1, 1};
      logic              op_we [5] = '{1, 1, 0, 0, 0};
      logic [ADDR_W-1:0] op_a  [5] = '{9'h003, 9'h004, 9'h003, 9'h004, 9'h003};
      logic [DATA_W-1:0] op_d  [5] = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00};
      int run = 0;
      int max_run = 0;
      want = '{8'hA5, 8'h5A, 8'hA5};
      for (int c = 0; c < 5 + LAT; c++) begin
         if (c < 5) issue(op_en[c], op_we[c], op_a[c], op_d[c], ent);
         else       issue(1'b0, 1'b0, '0, '0, ent);
         n_checks++;
         if ({rvalid, rdata} !== ent) begin
            n_fail++; $display("FAIL b2b c%0d: got %b/%h want %b/%h", c, rvalid, rdata, ent[DATA_W], ent[DATA_W-1:0]);
         end
         if (rvalid === 1'b1) begin obs.push_back(rdata); run++; end
         else run = 0;
         if (run > max_run) max_run = run;
      end
      n_checks++;
      if (obs.size() != 3 || max_run != 3) begin
         n_fail++; $display("FAIL b2b_count: got %0d pulses run %0d want 3 run 3", obs.size(), max_run);
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs[i] !== want[i]) begin n_fail++; $display("FAIL b2b_data %0d: got %h want %h", i, obs[i], want[i]); end
         end
      end
   endtask

   task automatic test_random();
      logic [DATA_W:0]   ent;
      logic [ADDR_W-1:0] a;
      for (int c = 0; c < 300 + LAT; c++) begin
         if (c < 300) begin
            a = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom_range(0, DEPTH - 1));
            issue(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a, DATA_W'($urandom_range(0, 255)), ent);
         end else begin
            issue(1'b0, 1'b0, '0, '0, ent);
         end
         n_checks++;
         if ({rvalid, rdata} !== ent) begin
            n_fail++; $display("FAIL random c%0d: got %b/%h want %b/%h", c, rvalid, rdata, ent[DATA_W], ent[DATA_W-1:0]);
         end
      end
   endtask

   task automatic test_write_during_clear();
      logic [DATA_W:0] ent;
      issue(1'b1, 1'b1, 9'h010, 8'h3C, ent);
      rst = 1'b1;
      set_in(1'b0, 1'b0, '0, '0);
      step();
      rst = 1'b0;
      // Partial sweep, then a reset in the middle must restart from zero.
      for (int i = 1; i <= 100; i++) begin
         set_in(1'b1, 1'b1, 9'h010, 8'hFF);
         step();
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 1; i <= DEPTH; i++) begin
         set_in(1'b1, ($urandom_range(0, 3) != 0), 9'h010, 8'hFF);
         step();
         n_checks++;
         if (ready !== (i == DEPTH)) begin
            n_fail++; $display("FAIL wdc_ready edge %0d: got %b want %b", i, ready, (i == DEPTH));
         end
         n_checks++;
         if (rvalid !== 1'b0) begin n_fail++; $display("FAIL wdc_rvalid edge %0d: got %b want 0", i, rvalid); end
      end
      set_in(1'b0, 1'b0, '0, '0);
      model_clear();
      for (int c = 0; c <= LAT; c++) begin
         if (c == 0) issue(1'b1, 1'b0, 9'h010, '0, ent);
         else        issue(1'b0, 1'b0, '0, '0, ent);
         n_checks++;
         if ({rvalid, rdata} !== ent) begin
            n_fail++; $display("FAIL wdc_read c%0d: got %b/%h want %b/%h", c, rvalid, rdata, ent[DATA_W], ent[DATA_W-1:0]);
         end
      end
   endtask

   task automatic test_rst_reclear();
      logic [DATA_W:0] ent;
      for (int c = 0; c < 2 + LAT; c++) begin
         if (c == 0)      issue(1'b1, 1'b1, 9'h020, 8'h77, ent);
         else if (c == 1) issue(1'b1, 1'b0, 9'h020, '0, ent);
         else             issue(1'b0, 1'b0, '0, '0, ent);
         n_checks++;
         if ({rvalid, rdata} !== ent) begin
            n_fail++; $display("FAIL rr_pre c%0d: got %b/%h want %b/%h", c, rvalid, rdata, ent[DATA_W], ent[DATA_W-1:0]);
         end
      end
      // A read accepted just before reset: only a latency-1 pipe may deliver it.
      set_in(1'b1, 1'b0, 9'h020, '0);
      step();
      n_checks++;
      if (rvalid !== (LAT == 1)) begin n_fail++; $display("FAIL rr_preflush: got %b want %b", rvalid, (LAT == 1)); end
      rst = 1'b1;
      set_in(1'b0, 1'b0, '0, '0);
      step();
      n_checks++;
      if (rvalid !== 1'b0 || rdata !== 8'h00 || ready !== 1'b0) begin
         n_fail++; $display("FAIL rr_flush: got rvalid %b rdata %h ready %b want 0/00/0", rvalid, rdata, ready);
      end
      rst = 1'b0;
      for (int i = 1; i <= 200; i++) begin
         step();
         n_checks++;
         if (ready !== 1'b0 || rvalid !== 1'b0) begin
            n_fail++; $display("FAIL rr_first_clear edge %0d: got ready %b rvalid %b want 0/0", i, ready, rvalid);
         end
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 1; i <= DEPTH; i++) begin
         step();
         n_checks++;
         if (ready !== (i == DEPTH) || rvalid !== 1'b0) begin
            n_fail++; $display("FAIL rr_second_clear edge %0d: got ready %b rvalid %b want %b/0", i, ready, rvalid, (i == DEPTH));
         end
      end
      model_clear();
      for (int c = 0; c <= LAT; c++) begin
         if (c == 0) issue(1'b1, 1'b0, 9'h020, '0, ent);
         else        issue(1'b0, 1'b0, '0, '0, ent);
         n_checks++;
         if ({rvalid, rdata} !== ent) begin
            n_fail++; $display("FAIL rr_read c%0d: got %b/%h want %b/%h", c, rvalid, rdata, ent[DATA_W], ent[DATA_W-1:0]);
         end
      end
   endtask

   // ---------------- sequence and final report ----------------
   initial begin
      test_reset();
      test_clear_read();
      test_back_to_back();
      test_random();
      test_write_during_clear();
      test_rst_reclear();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
